// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, the NOP encoding and the default reset PC.
// Later pipeline stages import this package as well.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the I-memory (slave).
// The read data is combinational and arrives in the same cycle as the address.
interface fetch_stage_if
  import pipeline_pkg::*;
#(
  parameter int XLEN = pipeline_pkg::XLEN
);
  logic [XLEN-1:0] IMemAddr;
  logic [31:0]     InstrF;

  modport master (output IMemAddr, input InstrF);
  modport slave  (input IMemAddr, output InstrF);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: rst > flush > enable; a flush loads a bubble.
// A capture from a misaligned PC keeps ValidD but replaces the instruction with a NOP.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            en,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o,
  output logic            misalign_o
);
  logic [31:0]     instr_d, instr_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
  logic            valid_d, valid_q;
  logic            misalign_d, misalign_q;
  logic            mis;

  assign mis = |pc_i[1:0];

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    if (flush) begin
      instr_d    = NOP_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else if (en) begin
      instr_d    = mis ? NOP_INSTR : instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
      misalign_d = mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;
  assign misalign_o = misalign_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, +4 adder, EX redirect mux and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush cycle counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            IFIDWrite,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            MisalignD,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     StallCyclesF,
  output logic [31:0]     FlushCyclesF,
`endif
  fetch_stage_if.master   imem
);
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic            squash;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign squash   = FlushD | PCSrcE;

  // A redirect wins even while the PC is stalled.
  always_comb begin
    pc_d = pc_q;
    if (PCSrcE)       pc_d = PCTargetE;
    else if (PCWrite) pc_d = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign PCF           = pc_q;
  assign imem.IMemAddr = {pc_q[XLEN-1:2], 2'b00};

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (squash),
    .en         (IFIDWrite),
    .instr_i    (imem.InstrF),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD),
    .misalign_o (MisalignD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!squash && !IFIDWrite && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (squash && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCyclesF = stall_cnt_q;
  assign FlushCyclesF = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one DUT at RESET_PC=0, one at 0xFFFF_FFFC.
// Instruction memory returns IMemAddr ^ 32'h0010_0093.
module tb_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'h0010_0093;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, PCWrite, IFIDWrite, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, MisalignD;
  logic [31:0] PCF2, InstrD2, PCD2, PCPlus4D2;
  logic        ValidD2, MisalignD2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus  ();
  fetch_stage_if bus2 ();
  assign bus.InstrF  = bus.IMemAddr ^ K;
  assign bus2.InstrF = bus2.IMemAddr ^ K;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .MisalignD(MisalignD),
`ifdef FETCH_PERF_CNT_EN
    .StallCyclesF(stall_a), .FlushCyclesF(flush_a),
`endif
    .imem(bus.master)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .PCF(PCF2), .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2),
    .ValidD(ValidD2), .MisalignD(MisalignD2),
`ifdef FETCH_PERF_CNT_EN
    .StallCyclesF(stall_b), .FlushCyclesF(flush_b),
`endif
    .imem(bus2.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1;
    FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    step(); step();
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rst_pcf got %h exp %h", PCF, 32'h0); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd got %h exp 0", PCD); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", PCPlus4D); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ValidD); end
    checks++; if (MisalignD !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", MisalignD); end
    checks++; if (PCF2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_pcf2 got %h exp fffffffc", PCF2); end
  endtask

  task automatic test_free_run();
    rst = 1'b0;
    step();
    checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL run1_pcf got %h exp 4", PCF); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL run1_valid got %b exp 1", ValidD); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL run1_pcd got %h exp 0", PCD); end
    checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL run1_pc4 got %h exp 4", PCPlus4D); end
    checks++; if (InstrD !== 32'h0010_0093) begin errors++; $display("FAIL run1_instr got %h exp 00100093", InstrD); end
    step();
    checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL run2_pcf got %h exp 8", PCF); end
    checks++; if (PCD !== 32'h4) begin errors++; $display("FAIL run2_pcd got %h exp 4", PCD); end
    checks++; if (PCPlus4D !== 32'h8) begin errors++; $display("FAIL run2_pc4 got %h exp 8", PCPlus4D); end
    checks++; if (InstrD !== 32'h0010_0097) begin errors++; $display("FAIL run2_instr got %h exp 00100097", InstrD); end
  endtask

  task automatic test_stall();
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL stall_pcf[%0d] got %h exp 8", i, PCF); end
      checks++; if (PCD !== 32'h4) begin errors++; $display("FAIL stall_pcd[%0d] got %h exp 4", i, PCD); end
      checks++; if (InstrD !== 32'h0010_0097) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 00100097", i, InstrD); end
    end
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    step();
    checks++; if (PCF !== 32'hC) begin errors++; $display("FAIL resume_pcf got %h exp c", PCF); end
    checks++; if (PCD !== 32'h8) begin errors++; $display("FAIL resume_pcd got %h exp 8", PCD); end
  endtask

  task automatic test_redirect();
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
    step();
    PCSrcE = 1'b0; FlushD = 1'b0;
    checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL redir_pcf got %h exp 100", PCF); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL redir_instr got %h exp %h", InstrD, NOP); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", ValidD); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL redir_pcd got %h exp 0", PCD); end
    step();
    checks++; if (PCF !== 32'h104) begin errors++; $display("FAIL redir2_pcf got %h exp 104", PCF); end
    checks++; if (PCD !== 32'h100) begin errors++; $display("FAIL redir2_pcd got %h exp 100", PCD); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL redir2_valid got %b exp 1", ValidD); end
    checks++; if (InstrD !== 32'h0010_0193) begin errors++; $display("FAIL redir2_instr got %h exp 00100193", InstrD); end
  endtask

  task automatic test_redirect_stalled();
    PCSrcE = 1'b1; PCTargetE = 32'h200; PCWrite = 1'b0; IFIDWrite = 1'b0;
    step();
    checks++; if (PCF !== 32'h200) begin errors++; $display("FAIL rstl_pcf got %h exp 200", PCF); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rstl_valid got %b exp 0", ValidD); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL rstl_instr got %h exp %h", InstrD, NOP); end
    PCSrcE = 1'b0; FlushD = 1'b1;
    step();
    checks++; if (PCF !== 32'h200) begin errors++; $display("FAIL fstl_pcf got %h exp 200", PCF); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL fstl_valid got %b exp 0", ValidD); end
    FlushD = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1;
    step();
    checks++; if (PCF !== 32'h204) begin errors++; $display("FAIL rstl2_pcf got %h exp 204", PCF); end
    checks++; if (PCD !== 32'h200 || ValidD !== 1'b1) begin errors++; $display("FAIL rstl2_pcd got %h/%b exp 200/1", PCD, ValidD); end
  endtask

  task automatic test_misalign();
    PCSrcE = 1'b1; PCTargetE = 32'h102;
    step();
    PCSrcE = 1'b0;
    checks++; if (PCF !== 32'h102) begin errors++; $display("FAIL mis_pcf got %h exp 102", PCF); end
    checks++; if (bus.IMemAddr !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 100", bus.IMemAddr); end
    step();
    checks++; if (PCF !== 32'h106) begin errors++; $display("FAIL mis2_pcf got %h exp 106", PCF); end
    checks++; if (MisalignD !== 1'b1) begin errors++; $display("FAIL mis2_flag got %b exp 1", MisalignD); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL mis2_instr got %h exp %h", InstrD, NOP); end
    checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL mis2_valid got %b exp 1", ValidD); end
    checks++; if (PCD !== 32'h102 || PCPlus4D !== 32'h106) begin errors++; $display("FAIL mis2_pcd got %h/%h exp 102/106", PCD, PCPlus4D); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_a !== 32'd2) begin errors++; $display("FAIL perf_stall got %0d exp 2", stall_a); end
    checks++; if (flush_a !== 32'd4) begin errors++; $display("FAIL perf_flush got %0d exp 4", flush_a); end
`endif
  endtask

  task automatic test_reset_mid_and_wrap();
    rst = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h300;
    step();
    rst = 1'b0; PCSrcE = 1'b0;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL mrst_pcf got %h exp 0", PCF); end
    checks++; if (ValidD !== 1'b0 || PCD !== 32'h0) begin errors++; $display("FAIL mrst_ifid got %b/%h exp 0/0", ValidD, PCD); end
    checks++; if (PCF2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mrst_pcf2 got %h exp fffffffc", PCF2); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_a !== 32'd0 || flush_a !== 32'd0) begin errors++; $display("FAIL mrst_perf got %0d/%0d exp 0/0", stall_a, flush_a); end
`endif
    step();
    checks++; if (PCF2 !== 32'h0) begin errors++; $display("FAIL wrap_pcf got %h exp 0", PCF2); end
    checks++; if (PCD2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcd got %h exp fffffffc", PCD2); end
    checks++; if (PCPlus4D2 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", PCPlus4D2); end
    checks++; if (ValidD2 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", ValidD2); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stalled();
    test_misalign();
    test_reset_mid_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage pipelined core.
- Holds the PC and drives the instruction-memory address. Registers the fetched instruction, PC and PC+4 into the Decode stage.
- Directly consumes the hazard controls PCWrite, IFIDWrite and FlushD, and the EX-stage redirect (PCSrcE/PCTargetE).

Parameters:
- XLEN, 32, datapath / PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- PCWrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
- IFIDWrite  input  1  1 = IF/ID register may capture; 0 = hold IF/ID.
- FlushD  input  1  1 = squash IF/ID contents (control hazard).
- PCSrcE  input  1  1 = EX redirect (taken branch / JAL / JALR).
- PCTargetE  input  XLEN  redirect target.
- IMemAddr  output  XLEN  instruction memory address, = {PCF[XLEN-1:2], 2'b00}.
- InstrF  input  32  instruction memory read data, combinational, same cycle as IMemAddr.
- PCF  output  XLEN  current fetch PC (raw, including low bits).
- InstrD  output  32  decode-stage instruction.
- PCD  output  XLEN  PC of InstrD.
- PCPlus4D  output  XLEN  PCD + 4.
- ValidD  output  1  InstrD is a real (non-bubble) instruction.
- MisalignD  output  1  InstrD was fetched from a PC with PC[1:0] != 0.

Behaviour:
- Reset, synchronous and active-high, dominates everything, including mid-operation:
  - PCF = RESET_PC.
  - InstrD = NOP (32'h0000_0013).
  - PCD = 0, PCPlus4D = 0, ValidD = 0, MisalignD = 0.
- PC next-state priority:
  - rst;
  - then PCSrcE → PCTargetE (taken regardless of PCWrite);
  - then PCWrite → PCF + 4;
  - else hold.
- PCF + 4 is modulo 2^XLEN: 32'hFFFF_FFFC → 32'h0000_0000.
- IF/ID next-state priority:
  - rst;
  - then (FlushD | PCSrcE) → bubble: InstrD = NOP, ValidD = 0, MisalignD = 0; PCD and PCPlus4D are loaded with 0;
  - then IFIDWrite → capture: InstrD = InstrF, PCD = PCF, PCPlus4D = PCF + 4, ValidD = 1, MisalignD = |PCF[1:0];
  - else hold all IF/ID fields.
- Flush beats stall. Simultaneous FlushD = 1 and IFIDWrite = 0 yields a bubble.
- Misaligned capture (|PCF[1:0] = 1): InstrD is forced to NOP, ValidD = 1, MisalignD = 1. PC continues at PCF + 4 (low bits preserved) until redirected.
- PCWrite and IFIDWrite are handled independently; no consistency check.
- Latency:
  - Instruction at PCF appears on InstrD one cycle later when IFIDWrite = 1.
  - After a redirect, the target instruction reaches InstrD two edges after PCSrcE is sampled.
- First valid decode instruction appears one cycle after rst deasserts (ValidD = 1, PCD = RESET_PC).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs StallCyclesF [31:0] and FlushCyclesF [31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - StallCyclesF increments each cycle with IFIDWrite = 0 and no flush/redirect.
  - FlushCyclesF increments each cycle with FlushD | PCSrcE.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package pipeline_pkg holds XLEN, NOP_INSTR (32'h0000_0013) and the default RESET_PC constant. Later stages share the package.
- One sub-module, if_id_reg: the IF/ID register with rst > flush > enable priority and the bubble fields. fetch_stage instantiates it alongside the PC register, the +4 adder and the redirect mux.

Test Plan:
- Reset then free-run with PCWrite = IFIDWrite = 1, InstrF = 32'h0010_0093 → PCF = 0, 4, 8; a cycle later PCD = 0, 4, ValidD = 1, PCPlus4D = 4, 8.
- Stall at PCF = 8: PCWrite = IFIDWrite = 0 for 2 cycles → PCF holds 8, InstrD and PCD hold 4 for 2 cycles, then resume at 12.
- Redirect: PCSrcE = 1, PCTargetE = 32'h0000_0100, FlushD = 1 for 1 cycle → next PCF = 0x100, InstrD = NOP, ValidD = 0; next cycle PCD = 0x100, ValidD = 1.
- Redirect while stalled: PCSrcE = 1, PCWrite = 0, IFIDWrite = 0 → PCF takes target, IF/ID is a bubble (flush beats stall).
- Misaligned target 32'h0000_0102 → PCF = 0x102, IMemAddr = 0x100, next cycle MisalignD = 1, InstrD = NOP, ValidD = 1.
- Wrap plus mid-run reset: RESET_PC = 32'hFFFF_FFFC → PCF goes to 0 next edge; asserting rst with PCSrcE = 1 → PCF = RESET_PC, ValidD = 0. With FETCH_PERF_CNT_EN defined, the counters match injected stall/flush cycle counts.
